// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level I2C master. Issues START, STOP, WRITE and
// READ_ACK/READ_NACK bus sequences, one command at a time, and returns one
// response per accepted command. Each bus bit is four phases of CLK_DIV clocks.
// Optional build macro I2C_MASTER_CLK_STRETCH_EN adds slave clock stretching
// (the SCL-high phase P1 is frozen while a slave holds SCL low).
module i2c_byte_master #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [2:0] cmd_i,
    input  logic [7:0] wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       rsp_ack_o,
    output logic       rsp_err_o,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       busy_o
);

    localparam logic [15:0] RELOAD   = 16'(CLK_DIV - 1);
    localparam logic [2:0]  OP_START = 3'b000;
    localparam logic [2:0]  OP_STOP  = 3'b001;
    localparam logic [2:0]  OP_WRITE = 3'b010;
    localparam logic [2:0]  OP_RACK  = 3'b011;
    localparam logic [2:0]  OP_RNACK = 3'b100;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_STOP, S_WBIT, S_WACK, S_RBIT, S_RACK, S_HOLD, S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q;
    logic [1:0]  phase_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        ack_q, nack_q, is_wr_q, is_rd_q, err_q, busy_q;
    logic        rsp_valid_q, rsp_ack_q, rsp_err_q;
    logic [7:0]  rsp_data_q;
    logic        freeze, phase_end, last_phase, scl_mid;
    logic        accept, cmd_err, cmd_go, on_bus;

`ifdef I2C_MASTER_CLK_STRETCH_EN
    // A slave holding SCL low while we release it stalls the high phase.
    assign freeze = (phase_q == 2'd1) && scl_o && !scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign freeze     = 1'b0;
`endif

    assign phase_end   = (cnt_q == 16'd0) && !freeze;
    assign last_phase  = phase_end && (phase_q == 2'd3);
    assign scl_mid     = phase_q[0] ^ phase_q[1];
    assign cmd_ready_o = (state_q == S_IDLE) || (state_q == S_HOLD);
    assign accept      = cmd_valid_i && cmd_ready_o;
    // Only START is meaningful on a free bus; opcodes above READ_NACK never are.
    assign cmd_err     = (state_q == S_IDLE) ? (cmd_i != OP_START) : (cmd_i > OP_RNACK);
    assign cmd_go      = accept && !cmd_err;
    assign on_bus      = (state_q != S_IDLE) && (state_q != S_HOLD) && (state_q != S_RESP);

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_ack_o   = rsp_ack_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;

    // Next-state selection and open-drain line levels for each state/phase.
    always_comb begin
        state_d = state_q;
        scl_o   = 1'b1;
        sda_o   = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = cmd_err ? S_RESP : S_START;
            end
            S_HOLD: begin
                scl_o = 1'b0;
                sda_o = 1'b0;
                if (accept) begin
                    if (cmd_err) state_d = S_RESP;
                    else begin
                        case (cmd_i)
                            OP_START: state_d = S_START;
                            OP_STOP:  state_d = S_STOP;
                            OP_WRITE: state_d = S_WBIT;
                            default:  state_d = S_RBIT;
                        endcase
                    end
                end
            end
            S_START: begin
                scl_o = scl_mid;
                sda_o = (phase_q < 2'd2);
                if (last_phase) state_d = S_RESP;
            end
            S_STOP: begin
                scl_o = (phase_q != 2'd0);
                sda_o = (phase_q >= 2'd2);
                if (last_phase) state_d = S_RESP;
            end
            S_WBIT: begin
                scl_o = scl_mid;
                sda_o = shift_q[7];
                if (last_phase && bit_q == 3'd7) state_d = S_WACK;
            end
            S_WACK: begin
                scl_o = scl_mid;
                if (last_phase) state_d = S_RESP;
            end
            S_RBIT: begin
                scl_o = scl_mid;
                if (last_phase && bit_q == 3'd7) state_d = S_RACK;
            end
            S_RACK: begin
                scl_o = scl_mid;
                sda_o = nack_q;
                if (last_phase) state_d = S_RESP;
            end
            S_RESP: begin
                // Lines keep the level of the state we return to.
                scl_o   = ~busy_q;
                sda_o   = ~busy_q;
                state_d = busy_q ? S_HOLD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state: FSM, phase timing, bus ownership and response registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            phase_q     <= 2'd0;
            bit_q       <= 3'd0;
            ack_q       <= 1'b0;
            nack_q      <= 1'b0;
            is_wr_q     <= 1'b0;
            is_rd_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_ack_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= 1'b0;
            if (accept) begin
                err_q   <= cmd_err;
                is_wr_q <= cmd_go && (cmd_i == OP_WRITE);
                is_rd_q <= cmd_go && ((cmd_i == OP_RACK) || (cmd_i == OP_RNACK));
                nack_q  <= (cmd_i == OP_RNACK);
                ack_q   <= 1'b0;
                cnt_q   <= RELOAD;
                phase_q <= 2'd0;
                bit_q   <= 3'd0;
            end else if (on_bus) begin
                if (phase_end) begin
                    cnt_q   <= RELOAD;
                    phase_q <= phase_q + 2'd1;
                    if (phase_q == 2'd3) bit_q <= bit_q + 3'd1;
                end else if (!freeze) begin
                    cnt_q <= cnt_q - 16'd1;
                end
                if (state_q == S_WACK && phase_end && phase_q == 2'd1) ack_q <= ~sda_i;
                if (state_q == S_START && last_phase) busy_q <= 1'b1;
                if (state_q == S_STOP && last_phase) busy_q <= 1'b0;
            end
            if (state_q == S_RESP) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= err_q;
                rsp_ack_q   <= is_wr_q & ack_q;
                if (is_rd_q) rsp_data_q <= shift_q;
            end
        end
    end

    // Byte shifter: loads write data, shifts out after each bit, samples reads in P1.
    always_ff @(posedge clk_i) begin
        if (cmd_go && cmd_i == OP_WRITE) shift_q <= wdata_i;
        else if (state_q == S_WBIT && last_phase) shift_q <= {shift_q[6:0], 1'b0};
        else if (state_q == S_RBIT && phase_end && phase_q == 2'd1) shift_q <= {shift_q[6:0], sda_i};
    end

endmodule

// File: doc/i2c_byte_master.md
I2C_BYTE_MASTER -- requirements
Module: i2c_byte_master

Interface
REQ-001 Parameter CLK_DIV, default 250, meaning clk_i cycles per SCL quarter-bit phase (100 MHz / (4*250) = 100 kHz SCL); legal range 2..65535.
REQ-002 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous assert, synchronous de-assert, active-low.
REQ-004 cmd_valid_i  input  1  command request.
REQ-005 cmd_ready_o  output  1  command accepted when cmd_valid_i && cmd_ready_o on a clk_i edge.
REQ-006 cmd_i  input  3  opcode: 000 START, 001 STOP, 010 WRITE, 011 READ_ACK, 100 READ_NACK; others illegal.
REQ-007 wdata_i  input  8  byte for WRITE, sampled at acceptance.
REQ-008 rsp_valid_o  output  1  one-cycle pulse per accepted command; no backpressure.
REQ-009 rsp_data_o  output  8  byte received by READ_*; holds value until next READ completes.
REQ-010 rsp_ack_o  output  1  WRITE: 1 = slave ACKed (SDA low in ACK slot); 0 otherwise.
REQ-011 rsp_err_o  output  1  command rejected; valid with rsp_valid_o.
REQ-012 scl_o  output  1  SCL drive, open-drain: 0 = pull low, 1 = release.
REQ-013 sda_o  output  1  SDA drive, open-drain: 0 = pull low, 1 = release (wired-AND with slave).
REQ-014 scl_i, sda_i  input  1 each  sampled bus lines.
REQ-015 busy_o  output  1  high from START completion until STOP completion (bus owned).

Function
REQ-016 States: IDLE, START, STOP, WBIT, WACK, RBIT, RACK, HOLD, RESP; cmd_ready_o high only in IDLE and HOLD.
REQ-017 Each bus bit = 4 phases P0..P3 of CLK_DIV cycles, timed by a 16-bit down-counter reloaded at each phase boundary.
REQ-018 Data/ACK bit: P0 SCL low, SDA set; P1,P2 SCL released; P3 SCL low; SDA changes only in P0.
REQ-019 sda_i sampled on last cycle of P1 for RBIT and WACK.
REQ-020 START (from IDLE or HOLD = repeated start): P0 SCL0/SDA1, P1 SCL1/SDA1, P2 SCL1/SDA0, P3 SCL0/SDA0; then HOLD, busy_o=1.
REQ-021 STOP: P0 SCL0/SDA0, P1 SCL1/SDA0, P2 SCL1/SDA1, P3 SCL1/SDA1; then IDLE, busy_o=0.
REQ-022 WRITE: 8 WBIT MSB-first then one WACK bit with SDA released; rsp_ack_o = ~sampled sda_i.
REQ-023 READ_ACK/READ_NACK: 8 RBIT with SDA released, MSB-first into shift register; RACK drives SDA 0 (ACK) or 1 (NACK).
REQ-024 Latency, acceptance edge to rsp_valid_o: START/STOP 4*CLK_DIV+1 cycles; WRITE/READ 36*CLK_DIV+1 cycles.
REQ-025 In HOLD, SCL and SDA held low (SCL low, bus stalled) until next command.
REQ-026 Errors (rsp_err_o=1, rsp_valid_o after 1 cycle, no bus activity, state unchanged): WRITE/READ/STOP in IDLE; illegal opcode in any ready state.
REQ-027 cmd_valid_i while cmd_ready_o=0 is ignored; no queueing.
REQ-028 rsp_ack_o and rsp_err_o are 0 on every response where not set per REQ-022/REQ-026.

Reset
REQ-029 rst_i low forces IDLE immediately: scl_o=1, sda_o=1, cmd_ready_o=1, rsp_valid_o=0, rsp_data_o=8'h00, rsp_ack_o=0, rsp_err_o=0, busy_o=0, counter=0.
REQ-030 Reset mid-transfer releases both lines at once, generates no STOP and emits no response for the aborted command.

Configuration
REQ-031 Macro I2C_MASTER_CLK_STRETCH_EN: when defined, P1 counter is frozen while scl_o=1 and scl_i=0 (slave clock stretching), resuming on first cycle scl_i=1; latencies extend by stretch length.
REQ-032 Without I2C_MASTER_CLK_STRETCH_EN, scl_i is unused and timing is exactly per REQ-024.

Verification
REQ-033 CLK_DIV=4: START, WRITE 8'h88 to slave at 7'h44 ACKing -> SDA bits 1000_1000 on SCL rises, rsp_ack_o=1, rsp latency 145 cycles.
REQ-034 START, WRITE 8'h89, READ_ACK with slave sending 8'hA5, READ_NACK with 8'h3C, STOP -> rsp_data_o 8'hA5 then 8'h3C, SDA low then high in ACK slots, busy_o 0 after STOP.
REQ-035 WRITE to absent address (SDA floats high) -> rsp_ack_o=0, rsp_err_o=0, state HOLD.
REQ-036 WRITE in IDLE, then opcode 3'b111 -> two responses with rsp_err_o=1, scl_o/sda_o stay 1.
REQ-037 START, WRITE, START, READ_NACK, STOP -> repeated start seen as SDA fall with SCL high, no STOP between.
REQ-038 rst_i low during bit 4 of a WRITE -> scl_o=sda_o=1 same cycle, no rsp_valid_o; with I2C_MASTER_CLK_STRETCH_EN, slave holding SCL low 50 cycles delays response by 50 cycles.
